// File: rtl/image_framer_pkg.sv
// Shared definitions for the image framer: frame geometry, default binarization
// level and the controller state encoding.
package image_framer_pkg;
  localparam int NPIX_DEF      = 784;
  localparam int THRESHOLD_DEF = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FIRE = 2'd2,
    WAIT = 2'd3
  } state_t;
endpackage

// File: rtl/image_framer.sv
// Collects a frame of grayscale pixels, binarizes each against THRESHOLD and
// hands the packed frame to the classifier with a one-cycle start pulse.
module image_framer
  import image_framer_pkg::*;
#(
  parameter int NPIX      = NPIX_DEF,
  parameter int THRESHOLD = THRESHOLD_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      pix_data,
  input  logic            pix_valid,
  input  logic            pix_sof,
  output logic            pix_ready,
  output logic [NPIX-1:0] image_out,
  output logic            start,
  input  logic            mdl_valid,
  output logic            busy,
  output logic            frame_err
);
  localparam int IW = $clog2(NPIX);

  state_t        state;
  logic [IW-1:0] idx;
  logic          accept;
  logic          bin;

  assign pix_ready = (state == IDLE) || (state == LOAD);
  assign accept    = pix_valid && pix_ready;
  assign bin       = (32'(pix_data) >= THRESHOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      image_out <= '0;
      start     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      start     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          // Stray pixels outside a frame are silently discarded.
          if (accept && pix_sof) begin
            image_out[0] <= bin;
            idx          <= IW'(1);
            state        <= LOAD;
            busy         <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            if (pix_sof) begin
              // Restart: drop the partial frame and begin again at this pixel.
              frame_err <= 1'b1;
              image_out <= {{(NPIX-1){1'b0}}, bin};
              idx       <= IW'(1);
            end else begin
              image_out[idx] <= bin;
              if (idx == IW'(NPIX-1)) begin
                idx   <= '0;
                state <= FIRE;
                start <= 1'b1;
              end else begin
                idx <= idx + IW'(1);
              end
            end
          end
        end
        FIRE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (mdl_valid) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
